draw_ray_hit: RTL and testbench

- Downstream of the raytracer; consumes its hit cell (result_x/result_y) after the top-level FSM pulses start.
- Plots a solid CELL_PX x CELL_PX marker over that cell on the grid map that draw_grid already drew.
- Before plotting, erases the previous marker by redrawing that cell in its stored grid colour.
- Shares the grid memory read port and the VGA write port with the other stages, one stage at a time under top-level FSM control.

---
 rtl/draw_ray_hit.sv | 118 +++++++++++
 tb/tb_draw_ray_hit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/draw_ray_hit.sv
// draw_ray_hit: erase the previous hit-cell marker, then plot a marker on the new hit cell (define MARKER_TRAIL_EN to keep old markers as a trail)
module draw_ray_hit #(
  parameter int CELL_PX = 2,
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0,
  parameter logic [2:0] HIT_COLOUR = 3'b100,
  parameter logic [2:0] MISS_COLOUR = 3'b010
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  input  logic [5:0] hit_x,
  input  logic [4:0] hit_y,
  output logic [5:0] grid_x,
  output logic [4:0] grid_y,
  input  logic [2:0] grid_out,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_write
);
  localparam int SH = $clog2(CELL_PX);
  localparam logic [1:0] LAST = 2'(CELL_PX - 1);
  localparam logic [7:0] XO = 8'(X_OFFSET);
  localparam logic [6:0] YO = 7'(Y_OFFSET);
  typedef enum logic [2:0] {IDLE, ERASE_RD, ERASE_WAIT, ERASE_DRAW, MARK_RD, MARK_WAIT, MARK_DRAW, DONE} state_t;
  state_t state;
  logic have_prev;
  logic [5:0] cur_x, prev_x, dx;
  logic [4:0] cur_y, prev_y, dy;
  logic [1:0] px, py, nx, ny;
  logic last, erasing;
  function automatic logic [7:0] pix_x(input logic [5:0] c, input logic [1:0] p);
    return XO + (8'(c) << SH) + 8'(p);
  endfunction
  function automatic logic [6:0] pix_y(input logic [4:0] c, input logic [1:0] p);
    return YO + (7'(c) << SH) + 7'(p);
  endfunction
  // Next pixel within the cell and which cell the current phase is painting
  always_comb begin
    last = px == LAST && py == LAST;
    nx = px == LAST ? 2'd0 : px + 2'd1;
    ny = px == LAST ? py + 2'd1 : py;
    erasing = state == ERASE_WAIT || state == ERASE_DRAW;
    dx = erasing ? prev_x : cur_x;
    dy = erasing ? prev_y : cur_y;
  end
  // Sequencer; every output is registered and set on entry to the state that owns it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      have_prev <= 1'b0;
      done <= 1'b0;
      vga_write <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      grid_x <= '0;
      grid_y <= '0;
      cur_x <= '0;
      cur_y <= '0;
      prev_x <= '0;
      prev_y <= '0;
      px <= '0;
      py <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            cur_x <= hit_x;
            cur_y <= hit_y;
`ifdef MARKER_TRAIL_EN
            state <= MARK_RD;
            grid_x <= hit_x;
            grid_y <= hit_y;
`else
            state <= have_prev ? ERASE_RD : MARK_RD;
            grid_x <= have_prev ? prev_x : hit_x;
            grid_y <= have_prev ? prev_y : hit_y;
`endif
          end
        ERASE_RD: state <= ERASE_WAIT;
        MARK_RD: state <= MARK_WAIT;
        ERASE_WAIT, MARK_WAIT: begin
          state <= erasing ? ERASE_DRAW : MARK_DRAW;
          vga_colour <= erasing ? grid_out : (grid_out != 3'd0 ? HIT_COLOUR : MISS_COLOUR);
          px <= '0;
          py <= '0;
          vga_x <= pix_x(dx, 2'd0);
          vga_y <= pix_y(dy, 2'd0);
          vga_write <= 1'b1;
        end
        ERASE_DRAW, MARK_DRAW:
          if (last) begin
            vga_write <= 1'b0;
            state <= erasing ? MARK_RD : DONE;
            done <= !erasing;
            grid_x <= cur_x;
            grid_y <= cur_y;
          end else begin
            px <= nx;
            py <= ny;
            vga_x <= pix_x(dx, nx);
            vga_y <= pix_y(dy, ny);
          end
        DONE: begin
          prev_x <= cur_x;
          prev_y <= cur_y;
          have_prev <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_ray_hit.sv
// tb_draw_ray_hit: directed checks of marker erase/plot sequencing on two instances (default and wrapping offsets)
module tb_draw_ray_hit;
`ifdef MARKER_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [5:0] hit_x = '0, gx1, gx2;
  logic [4:0] hit_y = '0, gy1, gy2;
  logic done1, done2, vw1, vw2;
  logic [2:0] go1, go2, vc1, vc2;
  logic [7:0] vx1, vx2;
  logic [6:0] vy1, vy2;
  logic [2:0] mem [64][32];
  logic [17:0] q1[$], q2[$], e1[$], e2[$];
  int n_assert = 0, n_fail = 0, dcnt1 = 0, dcnt2 = 0, xcnt = 0, pcx = 0, pcy = 0;
  bit have_prev = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    go1 <= mem[gx1][gy1];
    go2 <= mem[gx2][gy2];
  end

  draw_ray_hit dut1 (
    .clock(clock), .reset(reset), .start(start), .done(done1), .hit_x(hit_x), .hit_y(hit_y),
    .grid_x(gx1), .grid_y(gy1), .grid_out(go1), .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1), .vga_write(vw1)
  );

  draw_ray_hit #(.X_OFFSET(140), .Y_OFFSET(70)) dut2 (
    .clock(clock), .reset(reset), .start(start), .done(done2), .hit_x(hit_x), .hit_y(hit_y),
    .grid_x(gx2), .grid_y(gy2), .grid_out(go2), .vga_x(vx2), .vga_y(vy2), .vga_colour(vc2), .vga_write(vw2)
  );

  always @(negedge clock) begin
    if (reset) begin
      if (vw1) q1.push_back({vx1, vy1, vc1});
      if (vw2) q2.push_back({vx2, vy2, vc2});
      if (done1) dcnt1++;
      if (done2) dcnt2++;
      if ($isunknown({done1, vw1, vx1, vy1, vc1, gx1, gy1, done2, vw2, vx2, vy2, vc2, gx2, gy2})) xcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_cell(input int cx, input int cy, input logic [2:0] c);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) begin
        e1.push_back({8'((cx * 2 + x) % 256), 7'((cy * 2 + y) % 128), c});
        e2.push_back({8'((140 + cx * 2 + x) % 256), 7'((70 + cy * 2 + y) % 128), c});
      end
  endtask

  task automatic run(input int cx, input int cy, input logic [2:0] g, input int extra, input string tag);
    int n;
    mem[cx][cy] = g;
    q1.delete(); q2.delete(); e1.delete(); e2.delete();
    dcnt1 = 0; dcnt2 = 0;
    if (have_prev && !TRAIL) exp_cell(pcx, pcy, mem[pcx][pcy]);
    exp_cell(cx, cy, g != 3'd0 ? 3'b100 : 3'b010);
    @(negedge clock);
    start = 1'b1; hit_x = 6'(cx); hit_y = 5'(cy);
    @(negedge clock);
    start = 1'b0; hit_x = ~hit_x; hit_y = ~hit_y;
    n = 1;
    while (!done1 && n < 40) begin
      if (n == extra) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    chk({tag, " latency"}, n, (have_prev && !TRAIL) ? 13 : 7);
    chk({tag, " done2"}, {31'd0, done2}, 1);
    repeat (extra > 0 ? 20 : 2) @(negedge clock);
    chk({tag, " done pulses 1"}, dcnt1, 1);
    chk({tag, " done pulses 2"}, dcnt2, 1);
    chk({tag, " writes 1"}, q1.size(), e1.size());
    chk({tag, " writes 2"}, q2.size(), e2.size());
    for (int i = 0; i < e1.size(); i++) begin
      chk({tag, " pixel 1"}, {14'd0, i < q1.size() ? q1[i] : 18'h3ffff}, {14'd0, e1[i]});
      chk({tag, " pixel 2"}, {14'd0, i < q2.size() ? q2[i] : 18'h3ffff}, {14'd0, e2[i]});
    end
    have_prev = 1'b1; pcx = cx; pcy = cy;
  endtask

  initial begin
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++) mem[x][y] = 3'd0;
    repeat (2) @(negedge clock);
    chk("reset outputs 1", {1'b0, done1, vw1, vx1, vy1, vc1, gx1, gy1}, 0);
    chk("reset outputs 2", {1'b0, done2, vw2, vx2, vy2, vc2, gx2, gy2}, 0);
    reset = 1'b1;
    run(5, 3, 3'b001, 0, "first hit");
    run(0, 0, 3'b000, 0, "miss after hit");
    run(63, 31, 3'b000, 0, "edge cell wrap");
    run(2, 1, 3'b101, TRAIL ? 4 : 10, "start while busy");
    mem[7][7] = 3'd0;
    @(negedge clock);
    start = 1'b1; hit_x = 6'd7; hit_y = 5'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("drawing before reset", {31'd0, vw1}, 1);
    #1 reset = 1'b0;
    #1;
    chk("async reset outputs 1", {1'b0, done1, vw1, vx1, vy1, vc1, gx1, gy1}, 0);
    chk("async reset outputs 2", {1'b0, done2, vw2, vx2, vy2, vc2, gx2, gy2}, 0);
    repeat (2) @(negedge clock);
    chk("held in reset", {30'd0, vw1, vw2}, 0);
    reset = 1'b1;
    have_prev = 1'b0;
    run(5, 3, 3'b001, 0, "after reset");
    run(5, 3, 3'b001, 0, "same cell");
    chk("no unknown outputs", xcnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
